// File: rtl/div_pkg.sv
// Shared definitions for the sequential 8/4 restoring divider:
// state encoding, default operand widths and the iteration-count width.
package div_pkg;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;
  localparam int CW     = $clog2(DW_DEF + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/div8x4_seq_lzc8.sv
// lzc8: combinational leading-zero counter. An all-zero input returns DW.
// Only instantiated by div8x4_seq when DIV_EARLY_TERM_EN is defined.
module lzc8
  import div_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int CW_OUT = CW
) (
  input  logic [DW-1:0]     din,
  output logic [CW_OUT-1:0] lz
);

  logic found;

  // Scan from the MSB; the first set bit fixes the count.
  always_comb begin
    lz    = CW_OUT'(DW);
    found = 1'b0;
    for (int i = DW - 1; i >= 0; i--) begin
      if (!found && din[i]) begin
        lz    = CW_OUT'(DW - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div8x4_seq.sv
// div8x4_seq: sequential restoring divider, one quotient bit per clock,
// valid/ready handshakes on both operand and result sides.
// Optional build macro: DIV_EARLY_TERM_EN skips the dividend's leading zeros
// (latency DW-lz) and short-cuts a zero dividend; results are unchanged.
module div8x4_seq
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero
);

  localparam int CNT_W = $clog2(DW + 1);

  state_t          state;
  logic [DW-1:0]   q_r;
  // The partial remainder is architecturally VW+1 bits, but after each
  // restoring step it is below the divisor, so its top bit is always zero
  // and only the low VW bits need storage.
  logic [VW-1:0]   rem_r;
  logic [VW-1:0]   dsr_r;
  logic [CNT_W-1:0] count;

  logic [VW:0]     trial;
  logic [VW:0]     diff;
  logic            qbit;
  logic [VW-1:0]   rem_nxt;
  logic [DW-1:0]   q_nxt;

  logic [DW-1:0]    load_q;
  logic [CNT_W-1:0] load_cnt;
  logic             zero_dvd;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial   = {rem_r, q_r[DW-1]};
    diff    = trial - {1'b0, dsr_r};
    qbit    = (trial >= {1'b0, dsr_r});
    rem_nxt = qbit ? diff[VW-1:0] : trial[VW-1:0];
    q_nxt   = {q_r[DW-2:0], qbit};
  end

`ifdef DIV_EARLY_TERM_EN
  logic [CNT_W-1:0] lz;

  lzc8 #(
    .DW     (DW),
    .CW_OUT (CNT_W)
  ) u_lzc (
    .din (dividend),
    .lz  (lz)
  );

  // Leading zeros of the dividend contribute only zero quotient bits and
  // leave the remainder at zero, so they are skipped at load time.
  always_comb begin
    load_q   = dividend << lz;
    load_cnt = CNT_W'(DW) - lz;
    zero_dvd = (dividend == '0);
  end
`else
  // Full-length iteration: every dividend bit takes one cycle.
  always_comb begin
    load_q   = dividend;
    load_cnt = CNT_W'(DW);
    zero_dvd = 1'b0;
  end
`endif

  // Control FSM and datapath registers, with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      q_r       <= '0;
      rem_r     <= '0;
      dsr_r     <= '0;
      count     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            dsr_r    <= divisor;
            rem_r    <= '0;
            q_r      <= load_q;
            count    <= load_cnt;
            in_ready <= 1'b0;
            // Direct-result paths enter DONE with out_valid low; it rises on
            // the following edge, giving them a one-cycle latency.
            if (divisor == '0) begin
              state     <= DONE;
              quotient  <= '1;
              remainder <= '0;
              div_zero  <= 1'b1;
            end else if (zero_dvd) begin
              state     <= DONE;
              quotient  <= '0;
              remainder <= '0;
              div_zero  <= 1'b0;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem_r <= rem_nxt;
          q_r   <= q_nxt;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quotient  <= q_nxt;
            remainder <= rem_nxt;
            div_zero  <= 1'b0;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div8x4_seq.sv
// Testbench for div8x4_seq: directed cases plus an exhaustive operand sweep
// and randomized back-pressure, checked against an arithmetic reference.
module tb_div8x4_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_zero;

  int n_chk;
  int n_err;

  div8x4_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference latency in edges from the accept edge to out_valid rising.
  function automatic int model_lat(input int a, input int b);
    if (b == 0) return 1;
`ifdef DIV_EARLY_TERM_EN
    if (a == 0) return 1;
    return $clog2(a + 1);
`else
    return 8;
`endif
  endfunction

  // One full transaction; called just after a rising edge with DUT idle.
  task automatic do_div(input int a, input int b, input int hold, input bit full);
    int lat;
    int eq;
    int er;
    int edz;
    eq  = (b == 0) ? 255 : a / b;
    er  = (b == 0) ? 0 : a % b;
    edz = (b == 0) ? 1 : 0;
    for (int k = 0; k < 30 && !in_ready; k++) begin
      @(posedge clk); #1;
    end
    if (full) chk("in_ready_idle", int'(in_ready), 1);
    dividend  = 8'(a);
    divisor   = 4'(b);
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    if (full) chk("in_ready_busy", int'(in_ready), 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("lat %0d/%0d", a, b), lat, model_lat(a, b));
    chk($sformatf("quo %0d/%0d", a, b), int'(quotient), eq);
    chk($sformatf("rem %0d/%0d", a, b), int'(remainder), er);
    chk($sformatf("dz %0d/%0d", a, b), int'(div_zero), edz);
    if (full) chk("in_ready_done", int'(in_ready), 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (full) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_quo", int'(quotient), eq);
        chk("hold_rem", int'(remainder), er);
        chk("hold_in_ready", int'(in_ready), 0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hs_valid_low", int'(out_valid), 0);
    if (full) chk("hs_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_quo", int'(quotient), 0);
    chk("rst_rem", int'(remainder), 0);
    chk("rst_dz", int'(div_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases from the plan.
    do_div(200, 7, 0, 1'b1);
    do_div(255, 1, 0, 1'b1);
    do_div(0, 15, 0, 1'b1);
    do_div(13, 0, 0, 1'b1);
    do_div(100, 9, 5, 1'b1);
    do_div(5, 3, 0, 1'b1);
    do_div(0, 5, 0, 1'b1);

    // Reset in the middle of a calculation aborts it.
    dividend = 8'd200;
    divisor  = 4'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_quo", int'(quotient), 0);
    chk("abort_rem", int'(remainder), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_valid_post", int'(out_valid), 0);
    do_div(45, 6, 0, 1'b1);

    // Exhaustive operand sweep.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_div(a, b, 0, 1'b0);
      end
    end

    // Random operands with random result back-pressure.
    for (int n = 0; n < 150; n++) begin
      do_div(int'($urandom_range(255, 0)), int'($urandom_range(15, 0)),
             int'($urandom_range(3, 0)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
